pipe_alu4_fwd: RTL and testbench
================================

# pipe_alu4_fwd

Parametrised single-clock successor to the team's four-stage register-bank ALU pipeline: operand read, execute, register write-back, memory store. Adds configurable data width, register count and memory depth, a valid qualifier, EX-stage operand forwarding so back-to-back dependent instructions need no stalls, a load-immediate op, illegal-op squashing and a registered memory read-back port. Sits between the instruction sequencer and the data memory consumers.

## Interface
- DATA_W, 16, datapath and register/memory word width (≥8)
- NREG, 16, register-bank entries; index width RW = $clog2(NREG)
- ADDR_W, 8, memory address width; depth 2**ADDR_W
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present this cycle
- rs1, rs2, rd  in  RW each  source/destination register indices
- func  in  4  opcode
- addr  in  ADDR_W  memory store address / immediate
- z_out  out  DATA_W  stage-3 result
- z_valid  out  1  z_out carries a valid, legal result
- err_illegal  out  1  one-cycle pulse, aligned with stage 3, for an illegal func
- rd_addr  in  ADDR_W  memory read-back address
- rd_data  out  DATA_W  mem[rd_addr], one cycle later

## Operation
- S1 (issue): on each edge latch regbank[rs1], regbank[rs2], rd, func, addr, in_valid.
- S2 (EX): ALU on S1 operands A, B; latch Z, rd, addr, valid, illegal.
- S3 (WB): if S2 valid and legal, regbank[rd] <= Z; copy to S3 reg (drives z_out).
- S4 (MEM): if S3 valid and legal, mem[S3 addr] <= S3 Z.
- func: 0 A+B, 1 A−B, 2 A*B (low DATA_W bits), 3 A, 4 B, 5 A&B, 6 A|B, 7 A^B, 8 −A, 9 −B, 10 A>>1 logical, 11 A<<2, 12 zero-extended addr (load immediate), 13–15 illegal.
- All arithmetic modulo 2**DATA_W; no carry/overflow flags.
- Illegal func: Z=0, flows down pipe with valid=1, illegal=1; no regbank or mem write; z_valid=0; err_illegal=1 in S3 cycle.
- Bubbles (in_valid=0) propagate; write nothing.
- Forwarding (EX operand mux, per operand): S2 result if S2 valid, legal and S2.rd==rs; else S3 result if same for S3; else S1-latched value. S2 has priority over S3.
- Reset: all valid bits 0, z_out=0, z_valid=0, err_illegal=0, rd_data=0, every regbank entry 0. Memory contents not cleared; S4 write suppressed in the reset cycle and the cycle after. Instructions in flight at reset are discarded.

## Timing
- Instruction accepted at edge t: S1 at t, S2 at t+1, regbank write and z_out/z_valid at t+2, mem write at t+3.
- Throughput one instruction per cycle; no backpressure, no stalls.
- Dependent instruction at distance 1 or 2 receives forwarded value; distance ≥3 reads the updated regbank.
- rd_data registered: rd_addr sampled at edge t, data valid after t. Same-edge store and read to one address returns old data.

## Configuration
- ALU_FWD_EN defined: forwarding muxes present as above.
- Undefined: EX uses S1-latched operands only; dependents at distance 1–2 see stale values (legacy behaviour). All else identical.

## Structure
- Package pipe_alu4_pkg: func enum (OP_ADD … OP_LDI), illegal-op predicate, default width constants.
- Sub-module pipe_alu4_core: purely combinational ALU (A, B, imm, func → Z, illegal), instantiated in S2.

## Test plan
- Reset, LDI r1←5, LDI r2←3 (spaced 3 cycles), ADD r3=r1+r2 addr 0x10 → z_out=8 at t+2, rd_data for 0x10 = 8.
- LDI r1←7 then immediately ADD r2=r1+r1 (distance 1) → z_out=14 with ALU_FWD_EN; 0 without.
- LDI r1←4, bubble, SUB r2=r1−r1... use LDI r5←1, then MUL r3=r1*r1 at distance 2 → 16 with forwarding.
- func=13 with rd=r1 holding 9 → err_illegal pulse at t+2, z_valid=0, r1 still 9, target mem word unchanged.
- DATA_W=16: LDI r1←0x0000, NEG r2=−r1 then SUB 0−1 → 0xFFFF; SHL of 0x4001 → 0x0004.
- Assert rst mid-stream with three instructions in flight → no regbank/mem writes afterwards, all outputs 0 next cycle.

Source files
------------

// File: rtl/pipe_alu4_pkg.sv
// Shared opcode encoding, illegal-op predicate and default geometry for the
// four-stage forwarding ALU pipeline.
package pipe_alu4_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NREG   = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_PASSA = 4'd3,
    OP_PASSB = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NEGA  = 4'd8,
    OP_NEGB  = 4'd9,
    OP_SHR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_LDI   = 4'd12
  } alu_op_e;

  function automatic logic is_illegal(input logic [3:0] f);
    return (f > OP_LDI);
  endfunction

endpackage

// File: rtl/pipe_alu4_core.sv
// Combinational EX-stage ALU: A, B, immediate and opcode to result plus an
// illegal-opcode flag. Illegal opcodes yield a zero result.
module pipe_alu4_core
  import pipe_alu4_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ADDR_W-1:0] imm_i,
  input  logic [3:0]        func_i,
  output logic [DATA_W-1:0] z_o,
  output logic              illegal_o
);

  always_comb begin
    illegal_o = is_illegal(func_i);
    z_o       = '0;
    case (func_i)
      OP_ADD:   z_o = a_i + b_i;
      OP_SUB:   z_o = a_i - b_i;
      OP_MUL:   z_o = a_i * b_i;
      OP_PASSA: z_o = a_i;
      OP_PASSB: z_o = b_i;
      OP_AND:   z_o = a_i & b_i;
      OP_OR:    z_o = a_i | b_i;
      OP_XOR:   z_o = a_i ^ b_i;
      OP_NEGA:  z_o = -a_i;
      OP_NEGB:  z_o = -b_i;
      OP_SHR:   z_o = a_i >> 1;
      OP_SHL:   z_o = a_i << 2;
      OP_LDI:   z_o = DATA_W'(imm_i);
      default:  z_o = '0;
    endcase
  end

endmodule

// File: rtl/pipe_alu4_fwd.sv
// Four-stage ALU pipeline (issue, EX, write-back, memory store) with a
// registered memory read-back port. Define ALU_FWD_EN for EX operand forwarding.
module pipe_alu4_fwd
  import pipe_alu4_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RW-1:0]     rs1,
  input  logic [RW-1:0]     rs2,
  input  logic [RW-1:0]     rd,
  input  logic [3:0]        func,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] z_out,
  output logic              z_valid,
  output logic              err_illegal,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regbank_q [NREG];
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [RW-1:0]     s1_rd_q;
  logic [3:0]        s1_func_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic [DATA_W-1:0] ex_a, ex_b, alu_z;
  logic              alu_ill;

  logic              s2_valid_q, s2_ill_q;
  logic [DATA_W-1:0] s2_z_q;
  logic [RW-1:0]     s2_rd_q;
  logic [ADDR_W-1:0] s2_addr_q;

  logic              s3_valid_q, s3_ill_q;
  logic [DATA_W-1:0] s3_z_q;
  logic [ADDR_W-1:0] s3_addr_q;

  logic [DATA_W-1:0] rd_data_q;

`ifdef ALU_FWD_EN
  logic [RW-1:0] s1_rs1_q, s1_rs2_q, s3_rd_q;
  logic          s2_fwd, s3_fwd;

  always_ff @(posedge clk) begin
    s1_rs1_q <= rs1;
    s1_rs2_q <= rs2;
    s3_rd_q  <= s2_rd_q;
  end

  assign s2_fwd = s2_valid_q & ~s2_ill_q;
  assign s3_fwd = s3_valid_q & ~s3_ill_q;

  // S3 applied first so a matching S2 result overrides it (younger wins).
  always_comb begin
    ex_a = s1_a_q;
    ex_b = s1_b_q;
    if (s3_fwd && (s3_rd_q == s1_rs1_q)) ex_a = s3_z_q;
    if (s3_fwd && (s3_rd_q == s1_rs2_q)) ex_b = s3_z_q;
    if (s2_fwd && (s2_rd_q == s1_rs1_q)) ex_a = s2_z_q;
    if (s2_fwd && (s2_rd_q == s1_rs2_q)) ex_b = s2_z_q;
  end
`else
  assign ex_a = s1_a_q;
  assign ex_b = s1_b_q;
`endif

  pipe_alu4_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu (
    .a_i       (ex_a),
    .b_i       (ex_b),
    .imm_i     (s1_addr_q),
    .func_i    (s1_func_q),
    .z_o       (alu_z),
    .illegal_o (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
      s1_func_q  <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_ill_q   <= 1'b0;
      s2_z_q     <= '0;
      s2_rd_q    <= '0;
      s2_addr_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_ill_q   <= 1'b0;
      s3_z_q     <= '0;
      s3_addr_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_a_q     <= regbank_q[rs1];
      s1_b_q     <= regbank_q[rs2];
      s1_rd_q    <= rd;
      s1_func_q  <= func;
      s1_addr_q  <= addr;
      s2_valid_q <= s1_valid_q;
      s2_ill_q   <= s1_valid_q & alu_ill;
      s2_z_q     <= s1_valid_q ? alu_z : '0;
      s2_rd_q    <= s1_rd_q;
      s2_addr_q  <= s1_addr_q;
      s3_valid_q <= s2_valid_q;
      s3_ill_q   <= s2_ill_q;
      s3_z_q     <= s2_z_q;
      s3_addr_q  <= s2_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regbank_q[i] <= '0;
    end else if (s2_valid_q && !s2_ill_q) begin
      regbank_q[s2_rd_q] <= s2_z_q;
    end
  end

  // Memory is never cleared; the rst gate drops the store already in S3.
  always_ff @(posedge clk) begin
    if (!rst && s3_valid_q && !s3_ill_q) mem_q[s3_addr_q] <= s3_z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem_q[rd_addr];
  end

  assign z_out       = s3_z_q;
  assign z_valid     = s3_valid_q & ~s3_ill_q;
  assign err_illegal = s3_valid_q & s3_ill_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_pipe_alu4_fwd.sv
// Bench for pipe_alu4_fwd: architectural model with scoreboard plus a
// table of hand-computed ALU results and multi-cycle hazard/reset sequences.
module tb_pipe_alu4_fwd;

  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_MUL = 4'd2, F_PA = 4'd3,
                         F_PB = 4'd4, F_OR = 4'd6, F_NEGA = 4'd8, F_SHL = 4'd11,
                         F_LDI = 4'd12;

  logic        clk = 1'b0;
  logic        rst, in_valid, z_valid, err_illegal;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, rd_addr;
  logic [15:0] z_out, rd_data;

  always #5 clk = ~clk;

  pipe_alu4_fwd #(.DATA_W(16), .NREG(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .z_out(z_out), .z_valid(z_valid),
    .err_illegal(err_illegal), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct { logic [15:0] z; logic zv; logic err; } exp_t;
  typedef struct { int unsigned cyc; logic [3:0] rd; logic [7:0] a; logic [15:0] z; } wr_t;
  typedef struct { logic [3:0] s1, s2, d, f; logic [7:0] a; logic [15:0] z; } vec_t;

  exp_t        sb[$];
  wr_t         rq[$], mq[$];
  logic [15:0] arch [16];
  logic [15:0] comm [16];
  logic [15:0] mmem [256];
  bit          mknown [256];
  int unsigned cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tbl [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_alu(input int f, input logic [15:0] a,
                                             input logic [15:0] b, input logic [7:0] imm);
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return a;
      4: return b;
      5: return a & b;
      6: return a | b;
      7: return a ^ b;
      8: return 16'h0000 - a;
      9: return 16'h0000 - b;
      10: return {1'b0, a[15:1]};
      11: return {a[13:0], 2'b00};
      12: return {8'h00, imm};
      default: return 16'h0000;
    endcase
  endfunction

  // Regbank write lands 2 edges after issue, mem write 3 edges after issue.
  task automatic commit_to(input int unsigned e);
    while (rq.size() > 0 && rq[0].cyc + 3 <= e) begin
      comm[rq[0].rd] = rq[0].z;
      void'(rq.pop_front());
    end
    while (mq.size() > 0 && mq[0].cyc + 4 <= e) begin
      mmem[mq[0].a]   = mq[0].z;
      mknown[mq[0].a] = 1'b1;
      void'(mq.pop_front());
    end
  endtask

  task automatic step(input bit v, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] d, input logic [3:0] f, input logic [7:0] a,
                      input bit use_exp, input logic [15:0] ez,
                      input logic [7:0] ra, input bit crd);
    logic [15:0] va, vb, z, erd;
    bit ill, known;
    exp_t e;
    wr_t w;
    commit_to(cyc);
`ifdef ALU_FWD_EN
    va = arch[s1]; vb = arch[s2];
`else
    va = comm[s1]; vb = comm[s2];
`endif
    ill = v && (f >= 4'd13);
    z = ill ? 16'h0000 : model_alu(int'(f), va, vb, a);
    if (use_exp) z = ez;
    if (v && !ill) begin
      arch[d] = z;
      w.cyc = cyc; w.rd = d; w.a = a; w.z = z;
      rq.push_back(w);
      mq.push_back(w);
    end
    e.z = z; e.zv = v && !ill; e.err = ill;
    sb.push_back(e);
    known = mknown[ra];
    erd   = mmem[ra];
    in_valid = v; rs1 = s1; rs2 = s2; rd = d; func = f; addr = a; rd_addr = ra;
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 2) begin
      e = sb.pop_front();
      if (e.zv || e.err) chk("z_out", z_out, e.z);
      chk("z_valid", {15'b0, z_valid}, {15'b0, e.zv});
      chk("err_illegal", {15'b0, err_illegal}, {15'b0, e.err});
    end
    if (crd && known) chk("rd_data", rd_data, erd);
  endtask

  task automatic op(input logic [3:0] f, input logic [3:0] d, input logic [3:0] s1,
                    input logic [3:0] s2, input logic [7:0] a);
    step(1'b1, s1, s2, d, f, a, 1'b0, 16'h0, 8'h00, 1'b0);
  endtask

  task automatic opx(input logic [3:0] f, input logic [3:0] d, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [7:0] a, input logic [15:0] ez);
    step(1'b1, s1, s2, d, f, a, 1'b1, ez, 8'h00, 1'b0);
  endtask

  task automatic bub(input logic [7:0] ra, input bit crd);
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 16'h0, ra, crd);
  endtask

  task automatic settle();
    repeat (3) bub(8'h00, 1'b0);
  endtask

  task automatic readback(input logic [7:0] ra, input int n);
    repeat (n) bub(ra, 1'b1);
  endtask

  task automatic do_reset();
    exp_t e;
    commit_to(cyc);
    rq.delete();
    mq.delete();
    for (int i = 0; i < 16; i++) begin arch[i] = '0; comm[i] = '0; end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    chk("rst z_out", z_out, 16'h0000);
    chk("rst z_valid", {15'b0, z_valid}, 16'h0000);
    chk("rst err_illegal", {15'b0, err_illegal}, 16'h0000);
    chk("rst rd_data", rd_data, 16'h0000);
    rst = 1'b0;
    sb.delete();
    e.z = '0; e.zv = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                              input logic [3:0] f, input logic [7:0] a, input logic [15:0] z);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.d = d; v.f = f; v.a = a; v.z = z;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // r1 = 0x0085, r2 = 0x000C for every table row.
    tbl[0]  = mk(1, 2, 3,  4'd0,  8'h20, 16'h0091);
    tbl[1]  = mk(1, 2, 4,  4'd1,  8'h21, 16'h0079);
    tbl[2]  = mk(1, 2, 5,  4'd2,  8'h22, 16'h063C);
    tbl[3]  = mk(1, 2, 6,  4'd3,  8'h23, 16'h0085);
    tbl[4]  = mk(1, 2, 7,  4'd4,  8'h24, 16'h000C);
    tbl[5]  = mk(1, 2, 8,  4'd5,  8'h25, 16'h0004);
    tbl[6]  = mk(1, 2, 9,  4'd6,  8'h26, 16'h008D);
    tbl[7]  = mk(1, 2, 10, 4'd7,  8'h27, 16'h0089);
    tbl[8]  = mk(1, 2, 11, 4'd8,  8'h28, 16'hFF7B);
    tbl[9]  = mk(1, 2, 12, 4'd9,  8'h29, 16'hFFF4);
    tbl[10] = mk(1, 2, 13, 4'd10, 8'h2A, 16'h0042);
    tbl[11] = mk(1, 2, 14, 4'd11, 8'h2B, 16'h0214);
    tbl[12] = mk(1, 2, 15, 4'd12, 8'hA5, 16'h00A5);
    tbl[13] = mk(1, 2, 3,  4'd13, 8'h2D, 16'h0000);
    tbl[14] = mk(1, 2, 3,  4'd14, 8'h2E, 16'h0000);
    tbl[15] = mk(1, 2, 3,  4'd15, 8'h2F, 16'h0000);
    tbl[16] = mk(2, 1, 3,  4'd1,  8'h2C, 16'hFF87);

    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0;
    addr = '0; rd_addr = '0;
    do_reset();
    do_reset();

    // Basic spaced LDI/ADD with store to 0x10 and read-back.
    opx(F_LDI, 4'd1, 4'd0, 4'd0, 8'd5, 16'h0005); settle();
    opx(F_LDI, 4'd2, 4'd0, 4'd0, 8'd3, 16'h0003); settle();
    opx(F_ADD, 4'd3, 4'd1, 4'd2, 8'h10, 16'h0008);
    readback(8'h10, 6);

    opx(F_LDI, 4'd1, 4'd0, 4'd0, 8'h85, 16'h0085); settle();
    opx(F_LDI, 4'd2, 4'd0, 4'd0, 8'h0C, 16'h000C); settle();
    for (int i = 0; i < 17; i++)
      step(1'b1, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].f, tbl[i].a, 1'b1, tbl[i].z, 8'h00, 1'b0);
    settle();
    readback(8'h22, 2);

    // Distance-1 dependency (S2 path); stale r1 is 0x85 without forwarding.
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'd7);
`ifdef ALU_FWD_EN
    opx(F_ADD, 4'd2, 4'd1, 4'd1, 8'h40, 16'h000E);
`else
    opx(F_ADD, 4'd2, 4'd1, 4'd1, 8'h40, 16'h010A);
`endif
    settle();

    // Distance-2 dependency (S3 path); stale r1 is 7.
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'd4);
    op(F_LDI, 4'd5, 4'd0, 4'd0, 8'd1);
`ifdef ALU_FWD_EN
    opx(F_MUL, 4'd3, 4'd1, 4'd1, 8'h41, 16'h0010);
`else
    opx(F_MUL, 4'd3, 4'd1, 4'd1, 8'h41, 16'h0031);
`endif
    settle();

    // Same register written at distance 1 and 2: younger result must win.
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'd1);
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'd2);
`ifdef ALU_FWD_EN
    opx(F_ADD, 4'd4, 4'd1, 4'd1, 8'h42, 16'h0004);
`else
    opx(F_ADD, 4'd4, 4'd1, 4'd1, 8'h42, 16'h0008);
`endif
    settle();

    // Distance 3 reads the updated regbank in either build.
    op(F_LDI, 4'd6, 4'd0, 4'd0, 8'h11);
    bub(8'h00, 1'b0); bub(8'h00, 1'b0);
    opx(F_ADD, 4'd7, 4'd6, 4'd6, 8'h43, 16'h0022);
    settle();

    // Illegal op targeting r1 and mem[0x30]: no writes, error pulse.
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'd9); settle();
    opx(F_PA, 4'd6, 4'd1, 4'd0, 8'h30, 16'h0009); settle();
    op(4'd13, 4'd1, 4'd1, 4'd1, 8'h30); settle();
    opx(F_PA, 4'd7, 4'd1, 4'd0, 8'h31, 16'h0009);
    readback(8'h30, 4);
    // Store and read of 0x30 on the same edge returns the old word.
    op(F_LDI, 4'd8, 4'd0, 4'd0, 8'h30);
    readback(8'h30, 5);

    // Wraparound and shift boundaries.
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'h00); settle();
    opx(F_NEGA, 4'd2, 4'd1, 4'd0, 8'h44, 16'h0000);
    op(F_LDI, 4'd3, 4'd0, 4'd0, 8'h01); settle();
    opx(F_SUB, 4'd4, 4'd1, 4'd3, 8'h45, 16'hFFFF); settle();
    op(F_LDI, 4'd1, 4'd0, 4'd0, 8'h40); settle();
    repeat (4) begin op(F_SHL, 4'd1, 4'd1, 4'd0, 8'h46); settle(); end
    op(F_LDI, 4'd2, 4'd0, 4'd0, 8'h01); settle();
    opx(F_OR, 4'd1, 4'd1, 4'd2, 8'h47, 16'h4001); settle();
    opx(F_SHL, 4'd9, 4'd1, 4'd0, 8'h48, 16'h0004); settle();

    // Reset with three stores in flight: none of them may land.
    op(F_LDI, 4'd8, 4'd0, 4'd0, 8'h55); settle();
    op(F_PA, 4'd10, 4'd8, 4'd0, 8'h50);
    op(F_PA, 4'd10, 4'd8, 4'd0, 8'h51);
    op(F_PA, 4'd10, 4'd8, 4'd0, 8'h52); settle();
    op(F_ADD, 4'd11, 4'd8, 4'd8, 8'h50);
    op(F_ADD, 4'd12, 4'd8, 4'd8, 8'h51);
    op(F_ADD, 4'd13, 4'd8, 4'd8, 8'h52);
    do_reset();
    readback(8'h50, 3);
    readback(8'h51, 2);
    readback(8'h52, 2);
    opx(F_PA, 4'd14, 4'd11, 4'd0, 8'h60, 16'h0000);
    opx(F_PB, 4'd14, 4'd0, 4'd8, 8'h61, 16'h0000);
    settle();
    readback(8'h50, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
